// File: rtl/dut_test_sequencer_if.sv
// Host/DUT-side bundle of the test sequencer: host command inputs, run status outputs
// and the flattened DUT slot buses.
interface dut_test_sequencer_if #(
  parameter int unsigned BITWIDTH_DATA   = 16,
  parameter int unsigned NUM_DUT         = 4,
  parameter int unsigned NUM_BITS_HEADER = 32,
  parameter int unsigned CNT_WIDTH       = 24
);
  localparam int unsigned SEL_WIDTH = $clog2(NUM_DUT) + 1;
  localparam int unsigned HEAD_W    = NUM_BITS_HEADER - 6;

  logic                                 START_FLAG;
  logic [SEL_WIDTH-1:0]                 SEL;
  logic [BITWIDTH_DATA-1:0]             DATA_IN;
  logic [BITWIDTH_DATA-1:0]             DATA_OUT;
  logic [NUM_BITS_HEADER-1:0]           HEAD_INFO;
  logic                                 RDY_FLAG;
  logic                                 BUSY;
  logic                                 TIMEOUT_FLAG;
  logic                                 SEL_ERR;
  logic [CNT_WIDTH-1:0]                 CYCLE_CNT;
  logic [NUM_DUT:0]                     DUT_EN;
  logic                                 DUT_START;
  logic [BITWIDTH_DATA-1:0]             DUT_DATA_IN;
  logic [(NUM_DUT+1)*BITWIDTH_DATA-1:0] DUT_DOUT;
  logic [(NUM_DUT+1)*HEAD_W-1:0]        DUT_HEAD;
  logic [NUM_DUT:0]                     DUT_RDY;

  modport master (
    output START_FLAG, SEL, DATA_IN, DUT_DOUT, DUT_HEAD, DUT_RDY,
    input  DATA_OUT, HEAD_INFO, RDY_FLAG, BUSY, TIMEOUT_FLAG, SEL_ERR,
           CYCLE_CNT, DUT_EN, DUT_START, DUT_DATA_IN
  );

  modport slave (
    input  START_FLAG, SEL, DATA_IN, DUT_DOUT, DUT_HEAD, DUT_RDY,
    output DATA_OUT, HEAD_INFO, RDY_FLAG, BUSY, TIMEOUT_FLAG, SEL_ERR,
           CYCLE_CNT, DUT_EN, DUT_START, DUT_DATA_IN
  );
endinterface

// File: rtl/dut_test_sequencer.sv
// DUT slot multiplexer with run sequencer: latches the slot on a start edge, pulses
// DUT_START once and measures latency until the selected DUT is ready or times out.
module dut_test_sequencer #(
  parameter int unsigned BITWIDTH_DATA   = 16,
  parameter int unsigned NUM_DUT         = 4,
  parameter int unsigned NUM_BITS_HEADER = 32,
  parameter int unsigned CNT_WIDTH       = 24,
  parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
  input logic                 CLK,
  input logic                 RSTN,
  dut_test_sequencer_if.slave bus
);
  localparam int unsigned SW     = $clog2(NUM_DUT) + 1;
  localparam int unsigned EN_W   = NUM_DUT + 1;
  localparam int unsigned HEAD_W = NUM_BITS_HEADER - 6;
  localparam logic [SW-1:0]        NUM_DUT_S = SW'(NUM_DUT);
  localparam logic [CNT_WIDTH-1:0] TMO      = CNT_WIDTH'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state_q, state_d;
  logic                     start_q;
  logic [SW-1:0]            sel_q, sel_d;
  logic [BITWIDTH_DATA-1:0] data_q, data_d;
  logic                     rdy_q, rdy_d;
  logic                     busy_q, busy_d;
  logic                     tmo_q, tmo_d;
  logic                     serr_q, serr_d;
  logic [CNT_WIDTH-1:0]     cyc_q, cyc_d;
  logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]     cnt_inc;
  logic [EN_W-1:0]          en_q, en_d;
  logic                     dstart_q, dstart_d;

  logic                     start_edge;
  logic                     sel_ok;
  logic                     head_ok;
  logic                     hit;
  logic [HEAD_W-1:0]        head_sel;

  assign start_edge = bus.START_FLAG & ~start_q;
  assign sel_ok     = (bus.SEL != '0) && (bus.SEL <= NUM_DUT_S);
  assign head_ok    = (bus.SEL <= NUM_DUT_S);
  assign hit        = bus.DUT_RDY[sel_q];
  assign cnt_inc    = cnt_q + CNT_WIDTH'(1);
  assign head_sel   = head_ok ? bus.DUT_HEAD[int'(bus.SEL)*HEAD_W +: HEAD_W] : '0;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q  <= IDLE;
      start_q  <= 1'b0;
      sel_q    <= '0;
      data_q   <= '0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
      tmo_q    <= 1'b0;
      serr_q   <= 1'b0;
      cyc_q    <= '0;
      cnt_q    <= '0;
      en_q     <= '0;
      dstart_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= bus.START_FLAG;
      sel_q    <= sel_d;
      data_q   <= data_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
      tmo_q    <= tmo_d;
      serr_q   <= serr_d;
      cyc_q    <= cyc_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      dstart_q <= dstart_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    data_d   = data_q;
    rdy_d    = rdy_q;
    busy_d   = busy_q;
    tmo_d    = tmo_q;
    serr_d   = serr_q;
    cyc_d    = cyc_q;
    cnt_d    = cnt_q;
    en_d     = en_q;
    dstart_d = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start_edge) begin
          if (sel_ok) begin
            sel_d    = bus.SEL;
            en_d     = EN_W'(1) << bus.SEL;
            dstart_d = 1'b1;
            cnt_d    = '0;
            rdy_d    = 1'b0;
            tmo_d    = 1'b0;
            serr_d   = 1'b0;
            busy_d   = 1'b1;
            state_d  = RUN;
          end else begin
            serr_d = 1'b1;
            rdy_d  = 1'b0;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_inc;
        // A ready on the timeout edge still counts as a successful result.
        if (hit) begin
          data_d  = bus.DUT_DOUT[int'(sel_q)*BITWIDTH_DATA +: BITWIDTH_DATA];
          cyc_d   = cnt_inc;
          rdy_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end else if (cnt_inc == TMO) begin
          tmo_d   = 1'b1;
          cyc_d   = TMO;
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.DATA_OUT     = data_q;
  assign bus.HEAD_INFO    = {6'(NUM_DUT), head_sel};
  assign bus.RDY_FLAG     = rdy_q;
  assign bus.BUSY         = busy_q;
  assign bus.TIMEOUT_FLAG = tmo_q;
  assign bus.SEL_ERR      = serr_q;
  assign bus.CYCLE_CNT    = cyc_q;
  assign bus.DUT_EN       = en_q;
  assign bus.DUT_START    = dstart_q;
  assign bus.DUT_DATA_IN  = bus.DATA_IN;
endmodule

// File: tb/tb_dut_test_sequencer.sv
// Scoreboard bench for dut_test_sequencer: expected run results are queued at start
// and compared when BUSY falls; status/boundary behaviour is checked directly.
module tb_dut_test_sequencer;
  localparam int unsigned BW = 16;
  localparam int unsigned ND = 4;
  localparam int unsigned HB = 32;
  localparam int unsigned CW = 24;
  localparam int unsigned TO = 1000;
  localparam int unsigned HW = HB - 6;

  typedef struct {
    logic          rdy;
    logic          tmo;
    logic [BW-1:0] data;
    logic [CW-1:0] cyc;
  } res_t;

  logic CLK  = 1'b0;
  logic RSTN = 1'b1;
  always #5 CLK = ~CLK;

  dut_test_sequencer_if #(
    .BITWIDTH_DATA(BW), .NUM_DUT(ND), .NUM_BITS_HEADER(HB), .CNT_WIDTH(CW)
  ) bus ();

  dut_test_sequencer #(
    .BITWIDTH_DATA(BW), .NUM_DUT(ND), .NUM_BITS_HEADER(HB), .CNT_WIDTH(CW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK (CLK),
    .RSTN(RSTN),
    .bus (bus)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  res_t sb[$];
  res_t exp_r;
  int   dstart_cnt = 0;
  int   busy_cnt   = 0;
  logic busy_prev  = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_done(input int max_cycles);
    int n = 0;
    while (bus.BUSY && n < max_cycles) begin
      tick();
      n++;
    end
    if (bus.BUSY) check_eq("wait_bound", 64'(bus.BUSY), 64'd0);
  endtask

  function automatic logic [HW-1:0] head_of(input int i);
    return HW'(32'h00ABC00 + i);
  endfunction

  always @(negedge CLK) begin
    if (!RSTN) begin
      busy_prev = 1'b0;
    end else begin
      if (bus.DUT_START) dstart_cnt++;
      if (bus.BUSY) busy_cnt++;
      if (busy_prev && !bus.BUSY) begin
        if (sb.size() == 0) begin
          check_eq("sb_unexpected", 64'(sb.size()), 64'd1);
        end else begin
          exp_r = sb.pop_front();
          check_eq("sb_rdy",  64'(bus.RDY_FLAG),     64'(exp_r.rdy));
          check_eq("sb_tmo",  64'(bus.TIMEOUT_FLAG), 64'(exp_r.tmo));
          check_eq("sb_data", 64'(bus.DATA_OUT),     64'(exp_r.data));
          check_eq("sb_cyc",  64'(bus.CYCLE_CNT),    64'(exp_r.cyc));
        end
      end
      busy_prev = bus.BUSY;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.START_FLAG = 1'b0;
    bus.SEL        = '0;
    bus.DATA_IN    = '0;
    bus.DUT_RDY    = '0;
    for (int i = 0; i <= ND; i++) begin
      bus.DUT_DOUT[i*BW +: BW] = BW'(16'h1111 * i);
      bus.DUT_HEAD[i*HW +: HW] = head_of(i);
    end
    bus.DUT_DOUT[1*BW +: BW] = 16'h00AB;

    #2 RSTN = 1'b0;
    repeat (2) tick();
    check_eq("rst_data",   64'(bus.DATA_OUT),     64'd0);
    check_eq("rst_rdy",    64'(bus.RDY_FLAG),     64'd0);
    check_eq("rst_busy",   64'(bus.BUSY),         64'd0);
    check_eq("rst_tmo",    64'(bus.TIMEOUT_FLAG), 64'd0);
    check_eq("rst_serr",   64'(bus.SEL_ERR),      64'd0);
    check_eq("rst_cyc",    64'(bus.CYCLE_CNT),    64'd0);
    check_eq("rst_en",     64'(bus.DUT_EN),       64'd0);
    check_eq("rst_dstart", 64'(bus.DUT_START),    64'd0);
    RSTN = 1'b1;
    tick();

    bus.DATA_IN = 16'h5A5A;
    bus.SEL     = 3'd3;
    #1;
    check_eq("data_fwd",    64'(bus.DUT_DATA_IN), 64'h5A5A);
    check_eq("head_slot3",  64'(bus.HEAD_INFO),   64'({6'd4, head_of(3)}));
    bus.SEL = 3'd5;
    #1;
    check_eq("head_oor",    64'(bus.HEAD_INFO),   64'({6'd4, 26'd0}));

    // 1) echo DUT on slot 1, ready in the start cycle
    tick();
    bus.SEL     = 3'd1;
    bus.DUT_RDY = 5'b00010;
    dstart_cnt  = 0;
    sb.push_back('{rdy: 1'b1, tmo: 1'b0, data: 16'h00AB, cyc: 24'd1});
    bus.START_FLAG = 1'b1;
    tick();
    check_eq("t1_dstart", 64'(bus.DUT_START), 64'd1);
    check_eq("t1_busy",   64'(bus.BUSY),      64'd1);
    check_eq("t1_en",     64'(bus.DUT_EN),    64'b00010);
    wait_done(20);
    tick();
    check_eq("t1_pulses", 64'(dstart_cnt), 64'd1);

    // 2) slot 4 ready 7 cycles after DUT_START
    bus.DUT_RDY    = '0;
    bus.START_FLAG = 1'b0;
    bus.SEL        = 3'd4;
    tick();
    sb.push_back('{rdy: 1'b1, tmo: 1'b0, data: 16'h4444, cyc: 24'd8});
    busy_cnt   = 0;
    dstart_cnt = 0;
    bus.START_FLAG = 1'b1;
    tick();
    repeat (7) tick();
    bus.DUT_RDY = 5'b10000;
    wait_done(20);
    tick();
    check_eq("t2_busy_len", 64'(busy_cnt),   64'd8);
    check_eq("t2_pulses",   64'(dstart_cnt), 64'd1);

    // 3) slot 2 never ready (slot 1 ready is ignored) -> timeout
    bus.DUT_RDY    = 5'b00010;
    bus.START_FLAG = 1'b0;
    bus.SEL        = 3'd2;
    tick();
    sb.push_back('{rdy: 1'b0, tmo: 1'b1, data: 16'h4444, cyc: 24'(TO)});
    bus.START_FLAG = 1'b1;
    tick();
    wait_done(TO + 100);
    tick();
    check_eq("t3_en", 64'(bus.DUT_EN), 64'b00100);

    // 4) invalid selections leave the finished run untouched
    bus.DUT_RDY    = '0;
    bus.START_FLAG = 1'b0;
    bus.SEL        = 3'd0;
    tick();
    dstart_cnt = 0;
    bus.START_FLAG = 1'b1;
    tick();
    tick();
    check_eq("t4_serr0",  64'(bus.SEL_ERR),      64'd1);
    check_eq("t4_busy",   64'(bus.BUSY),         64'd0);
    check_eq("t4_tmo",    64'(bus.TIMEOUT_FLAG), 64'd1);
    check_eq("t4_cyc",    64'(bus.CYCLE_CNT),    64'(TO));
    check_eq("t4_en",     64'(bus.DUT_EN),       64'b00100);
    check_eq("t4_data",   64'(bus.DATA_OUT),     64'h4444);
    bus.START_FLAG = 1'b0;
    bus.SEL        = 3'd5;
    tick();
    bus.START_FLAG = 1'b1;
    tick();
    tick();
    check_eq("t4_serr5",  64'(bus.SEL_ERR),   64'd1);
    check_eq("t4_rdy",    64'(bus.RDY_FLAG),  64'd0);
    check_eq("t4_pulses", 64'(dstart_cnt),    64'd0);
    check_eq("t4_busy5",  64'(bus.BUSY),      64'd0);

    // 5) SEL change, START re-edge and other-slot ready during a run are ignored
    bus.START_FLAG = 1'b0;
    bus.SEL        = 3'd3;
    tick();
    sb.push_back('{rdy: 1'b1, tmo: 1'b0, data: 16'h3333, cyc: 24'd6});
    dstart_cnt = 0;
    bus.START_FLAG = 1'b1;
    tick();
    bus.SEL        = 3'd1;
    bus.START_FLAG = 1'b0;
    tick();
    bus.START_FLAG = 1'b1;
    tick();
    bus.DUT_RDY = 5'b00010;
    tick();
    bus.DUT_RDY = '0;
    tick();
    tick();
    bus.DUT_RDY = 5'b01000;
    wait_done(20);
    tick();
    check_eq("t5_pulses", 64'(dstart_cnt),  64'd1);
    check_eq("t5_en",     64'(bus.DUT_EN),  64'b01000);
    check_eq("t5_serr",   64'(bus.SEL_ERR), 64'd0);

    // 6) reset mid-run, then a clean run
    bus.DUT_RDY    = '0;
    bus.START_FLAG = 1'b0;
    bus.SEL        = 3'd2;
    tick();
    bus.START_FLAG = 1'b1;
    tick();
    repeat (3) tick();
    RSTN = 1'b0;
    #1;
    check_eq("t6_busy",   64'(bus.BUSY),      64'd0);
    check_eq("t6_en",     64'(bus.DUT_EN),    64'd0);
    check_eq("t6_data",   64'(bus.DATA_OUT),  64'd0);
    check_eq("t6_dstart", 64'(bus.DUT_START), 64'd0);
    bus.START_FLAG = 1'b0;
    repeat (2) tick();
    RSTN = 1'b1;
    tick();
    check_eq("t6_idle_busy", 64'(bus.BUSY),      64'd0);
    check_eq("t6_idle_cyc",  64'(bus.CYCLE_CNT), 64'd0);
    bus.SEL     = 3'd1;
    bus.DUT_RDY = 5'b00010;
    sb.push_back('{rdy: 1'b1, tmo: 1'b0, data: 16'h00AB, cyc: 24'd1});
    dstart_cnt = 0;
    bus.START_FLAG = 1'b1;
    tick();
    check_eq("t6_restart", 64'(bus.DUT_START), 64'd1);
    wait_done(20);
    tick();
    check_eq("t6_pulses", 64'(dstart_cnt), 64'd1);

    check_eq("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
